// File: rtl/idx_vec_fifo_pkg.sv
// Shared types, default sizes and helpers for the multi-lane index FIFO.
package idx_fifo_pkg;

   localparam int unsigned IDX_W_D = 5;
   localparam int unsigned LANES_D = 16;
   localparam int unsigned DEPTH_D = 32;

   typedef logic [IDX_W_D-1:0] idx_t;

   // Pointer width for a power-of-two depth; never narrower than one bit.
   function automatic int unsigned ptr_w(input int unsigned depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/idx_vec_fifo_if.sv
// Valid/ready handshake bundle carrying LANES-wide index vectors in and out of the FIFO.
interface idx_vec_fifo_if
   import idx_fifo_pkg::*;
#(
   parameter int unsigned IDX_W = IDX_W_D,
   parameter int unsigned LANES = LANES_D
) ();

   logic             in_valid;
   logic             in_ready;
   logic [IDX_W-1:0] in_index  [LANES];
   logic             out_ready;
   logic             out_valid;
   logic [IDX_W-1:0] out_index [LANES];

   // Producer/consumer side driving the FIFO.
   modport master (
      output in_valid, in_index, out_ready,
      input  in_ready, out_valid, out_index
   );

   // FIFO side.
   modport slave (
      input  in_valid, in_index, out_ready,
      output in_ready, out_valid, out_index
   );

endinterface

// File: rtl/idx_vec_fifo_ram.sv
// Simple dual-port storage with a registered read port that doubles as the FIFO output register.
module idx_vec_ram
   import idx_fifo_pkg::*;
#(
   parameter int unsigned WORD_W = IDX_W_D * LANES_D,
   parameter int unsigned DEPTH  = DEPTH_D,
   parameter int unsigned ADDR_W = ptr_w(DEPTH_D)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [WORD_W-1:0] wdata_i,
   input  logic              re_i,
   input  logic [ADDR_W-1:0] raddr_i,
   output logic [WORD_W-1:0] rdata_o
);

   logic [WORD_W-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   // Read register clears on reset but holds its value whenever no read is issued.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdata_o <= '0;
      end else if (re_i) begin
         rdata_o <= mem_q[raddr_i];
      end
   end

endmodule

// File: rtl/idx_vec_fifo.sv
// Multi-lane index FIFO between index generation and FFT reorder/readout, with
// request-read or first-word-fall-through output, fill-level flags, flush and sticky underflow.
module idx_vec_fifo
   import idx_fifo_pkg::*;
#(
   parameter int unsigned IDX_W    = IDX_W_D,
   parameter int unsigned LANES    = LANES_D,
   parameter int unsigned DEPTH    = DEPTH_D,
   parameter int unsigned AF_LEVEL = DEPTH - 2,
   parameter int unsigned AE_LEVEL = 2,
   parameter bit          FWFT     = 1'b0
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         flush,
   input  logic                         clr_err,
   idx_vec_fifo_if.slave                bus,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         full,
   output logic                         empty,
   output logic                         almost_full,
   output logic                         almost_empty,
   output logic                         underflow
);

   localparam int unsigned PTR_W  = ptr_w(DEPTH);
   localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
   localparam int unsigned WORD_W = LANES * IDX_W;

   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              out_valid_q, out_valid_d;
   logic              underflow_q, underflow_d;

   logic              wr_en;
   logic              rd_en;
   logic              deq;
   logic              uf_evt;
   logic [WORD_W-1:0] wr_word;
   logic [WORD_W-1:0] rd_word;

   // Status decodes from the registered count only, so a pop at full never frees a same-cycle write.
   assign full         = (count_q == CNT_W'(DEPTH));
   assign empty        = (count_q == '0);
   assign almost_full  = (count_q >= CNT_W'(AF_LEVEL));
   assign almost_empty = (count_q <= CNT_W'(AE_LEVEL));
   assign count        = count_q;
   assign underflow    = underflow_q;
   assign bus.in_ready = !full;
   assign bus.out_valid = out_valid_q;

   // Lane vector <-> flat RAM word; lane i occupies bits [i*IDX_W +: IDX_W].
   always_comb begin
      wr_word = '0;
      for (int i = 0; i < int'(LANES); i++) begin
         wr_word[i*IDX_W +: IDX_W] = bus.in_index[i];
      end
   end

   always_comb begin
      for (int i = 0; i < int'(LANES); i++) begin
         bus.out_index[i] = rd_word[i*IDX_W +: IDX_W];
      end
   end

   // Handshake decode. In FWFT mode the read register is a one-entry head stage,
   // so storage occupancy is count minus the head-valid bit.
   always_comb begin
      wr_en  = 1'b0;
      rd_en  = 1'b0;
      deq    = 1'b0;
      uf_evt = 1'b0;
      if (!flush) begin
         wr_en = bus.in_valid && !full;
         if (FWFT) begin
            deq   = out_valid_q && bus.out_ready;
            rd_en = (!out_valid_q || bus.out_ready) && (count_q > CNT_W'(out_valid_q));
         end else begin
            rd_en  = bus.out_ready && !empty;
            deq    = rd_en;
            uf_evt = bus.out_ready && empty;
         end
      end
   end

   // Next-state for pointers, fill count, output valid and error flag.
   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      out_valid_d = out_valid_q;
      underflow_d = underflow_q;

      if (flush) begin
         wr_ptr_d    = '0;
         rd_ptr_d    = '0;
         count_d     = '0;
         out_valid_d = 1'b0;
      end else begin
         if (wr_en) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
         end
         if (rd_en) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         case ({wr_en, deq})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
         if (FWFT) begin
            out_valid_d = rd_en || (out_valid_q && !deq);
         end else begin
            out_valid_d = rd_en;
         end
      end

      // A new underflow in the same cycle as clr_err keeps the flag set.
      if (uf_evt) begin
         underflow_d = 1'b1;
      end else if (clr_err) begin
         underflow_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         out_valid_q <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         out_valid_q <= out_valid_d;
         underflow_q <= underflow_d;
      end
   end

   idx_vec_ram #(
      .WORD_W (WORD_W),
      .DEPTH  (DEPTH),
      .ADDR_W (PTR_W)
   ) u_ram (
      .clk     (clk),
      .rst     (rst),
      .we_i    (wr_en),
      .waddr_i (wr_ptr_q),
      .wdata_i (wr_word),
      .re_i    (rd_en),
      .raddr_i (rd_ptr_q),
      .rdata_o (rd_word)
   );

endmodule

// File: tb/tb_idx_vec_fifo.sv
// Scoreboard bench for idx_vec_fifo: one request-mode and one FWFT instance side by side.
module tb_idx_vec_fifo;
   import idx_fifo_pkg::*;

   localparam int unsigned IW = IDX_W_D;
   localparam int unsigned LN = LANES_D;
   localparam int unsigned DP = DEPTH_D;
   localparam int unsigned WW = IW * LN;
   localparam int unsigned CW = $clog2(DP + 1);

   logic clk = 1'b0;
   logic rst, flush, clr_err;

   logic [CW-1:0] r_count, w_count;
   logic r_full, r_empty, r_af, r_ae, r_uf;
   logic w_full, w_empty, w_af, w_ae, w_uf;

   idx_vec_fifo_if #(.IDX_W(IW), .LANES(LN)) ifr ();
   idx_vec_fifo_if #(.IDX_W(IW), .LANES(LN)) ifw ();

   logic [WW-1:0] r_in, w_in, r_out, w_out;
   logic [WW-1:0] sb_r [$];
   logic [WW-1:0] sb_w [$];
   logic [WW-1:0] exp_v, last_out;
   int vectors = 0;
   int miscompares = 0;
   int mcnt;

   always #5 clk = ~clk;

   always_comb begin
      for (int i = 0; i < int'(LN); i++) begin
         ifr.in_index[i] = r_in[i*IW +: IW];
         ifw.in_index[i] = w_in[i*IW +: IW];
      end
   end

   always_comb begin
      r_out = '0;
      w_out = '0;
      for (int i = 0; i < int'(LN); i++) begin
         r_out[i*IW +: IW] = ifr.out_index[i];
         w_out[i*IW +: IW] = ifw.out_index[i];
      end
   end

   idx_vec_fifo #(
      .IDX_W(IW), .LANES(LN), .DEPTH(DP), .AF_LEVEL(DP-2), .AE_LEVEL(2), .FWFT(1'b0)
   ) u_req (
      .clk(clk), .rst(rst), .flush(flush), .clr_err(clr_err), .bus(ifr),
      .count(r_count), .full(r_full), .empty(r_empty),
      .almost_full(r_af), .almost_empty(r_ae), .underflow(r_uf)
   );

   idx_vec_fifo #(
      .IDX_W(IW), .LANES(LN), .DEPTH(DP), .AF_LEVEL(DP-2), .AE_LEVEL(2), .FWFT(1'b1)
   ) u_fw (
      .clk(clk), .rst(rst), .flush(flush), .clr_err(clr_err), .bus(ifw),
      .count(w_count), .full(w_full), .empty(w_empty),
      .almost_full(w_af), .almost_empty(w_ae), .underflow(w_uf)
   );

   function automatic logic [WW-1:0] pat(input int k);
      logic [WW-1:0] v;
      v = '0;
      for (int i = 0; i < int'(LN); i++) v[i*IW +: IW] = IW'((k + i) % 32);
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Request-mode write; the model decides acceptance from its own fill count.
   task automatic req_push(input logic [WW-1:0] v);
      ifr.in_valid = 1'b1;
      r_in = v;
      if (mcnt < int'(DP)) begin
         sb_r.push_back(v);
         mcnt++;
      end
      tick();
      ifr.in_valid = 1'b0;
   endtask

   task automatic test_reset();
      vectors++; if (r_count !== CW'(0)) begin miscompares++; $display("FAIL rst_count got %0d want 0", r_count); end
      vectors++; if (r_empty !== 1'b1) begin miscompares++; $display("FAIL rst_empty got %b want 1", r_empty); end
      vectors++; if (r_full !== 1'b0) begin miscompares++; $display("FAIL rst_full got %b want 0", r_full); end
      vectors++; if (ifr.in_ready !== 1'b1) begin miscompares++; $display("FAIL rst_in_ready got %b want 1", ifr.in_ready); end
      vectors++; if (ifr.out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_out_valid got %b want 0", ifr.out_valid); end
      vectors++; if (r_uf !== 1'b0) begin miscompares++; $display("FAIL rst_underflow got %b want 0", r_uf); end
      vectors++; if (r_out !== '0) begin miscompares++; $display("FAIL rst_out_index got %h want 0", r_out); end
      vectors++; if (r_ae !== 1'b1 || r_af !== 1'b0) begin miscompares++; $display("FAIL rst_ae_af got %b%b want 10", r_ae, r_af); end
      vectors++; if (ifw.out_valid !== 1'b0 || w_out !== '0) begin miscompares++; $display("FAIL rst_fw_out got %b/%h want 0/0", ifw.out_valid, w_out); end
   endtask

   task automatic test_req_basic();
      for (int k = 0; k < 3; k++) req_push(pat(k));
      vectors++; if (r_count !== CW'(3)) begin miscompares++; $display("FAIL req_count3 got %0d want 3", r_count); end
      for (int j = 0; j < 3; j++) begin
         ifr.out_ready = 1'b1;
         exp_v = sb_r.pop_front();
         mcnt--;
         tick();
         ifr.out_ready = 1'b0;
         vectors++; if (ifr.out_valid !== 1'b1) begin miscompares++; $display("FAIL req_valid_%0d got %b want 1", j, ifr.out_valid); end
         vectors++; if (r_out !== exp_v) begin miscompares++; $display("FAIL req_data_%0d got %h want %h", j, r_out, exp_v); end
         vectors++; if (r_count !== CW'(2 - j)) begin miscompares++; $display("FAIL req_count_%0d got %0d want %0d", j, r_count, 2 - j); end
         tick();
         vectors++; if (ifr.out_valid !== 1'b0) begin miscompares++; $display("FAIL req_pulse_%0d got %b want 0", j, ifr.out_valid); end
         vectors++; if (r_out !== exp_v) begin miscompares++; $display("FAIL req_hold_%0d got %h want %h", j, r_out, exp_v); end
      end
      last_out = exp_v;
   endtask

   task automatic test_underflow();
      ifr.out_ready = 1'b1;
      tick();
      ifr.out_ready = 1'b0;
      vectors++; if (ifr.out_valid !== 1'b0) begin miscompares++; $display("FAIL uf_valid got %b want 0", ifr.out_valid); end
      vectors++; if (r_uf !== 1'b1) begin miscompares++; $display("FAIL uf_set got %b want 1", r_uf); end
      vectors++; if (r_out !== last_out) begin miscompares++; $display("FAIL uf_hold got %h want %h", r_out, last_out); end
      tick(); tick();
      vectors++; if (r_uf !== 1'b1) begin miscompares++; $display("FAIL uf_sticky got %b want 1", r_uf); end
      clr_err = 1'b1; tick(); clr_err = 1'b0;
      vectors++; if (r_uf !== 1'b0) begin miscompares++; $display("FAIL uf_clear got %b want 0", r_uf); end
      ifr.out_ready = 1'b1; clr_err = 1'b1; tick(); ifr.out_ready = 1'b0; clr_err = 1'b0;
      vectors++; if (r_uf !== 1'b1) begin miscompares++; $display("FAIL uf_set_wins got %b want 1", r_uf); end
      clr_err = 1'b1; tick(); clr_err = 1'b0;
      vectors++; if (r_uf !== 1'b0) begin miscompares++; $display("FAIL uf_clear2 got %b want 0", r_uf); end
   endtask

   task automatic test_full_wrap();
      logic [WW-1:0] v;
      bit wv, rv, wr_exp, rd_exp;
      for (int k = 0; k < int'(DP); k++) begin
         vectors++; if (r_af !== (mcnt >= int'(DP) - 2) || r_ae !== (mcnt <= 2)) begin miscompares++; $display("FAIL fill_flags_%0d got af=%b ae=%b", mcnt, r_af, r_ae); end
         req_push(pat(100 + k));
      end
      vectors++; if (r_count !== CW'(DP)) begin miscompares++; $display("FAIL full_count got %0d want %0d", r_count, DP); end
      vectors++; if (r_full !== 1'b1 || ifr.in_ready !== 1'b0 || r_af !== 1'b1) begin miscompares++; $display("FAIL full_flags got full=%b rdy=%b af=%b want 1 0 1", r_full, ifr.in_ready, r_af); end
      req_push(pat(999));
      vectors++; if (r_count !== CW'(DP)) begin miscompares++; $display("FAIL full_drop got %0d want %0d", r_count, DP); end
      // Pop at full with a same-cycle write: the write must stall.
      ifr.out_ready = 1'b1; ifr.in_valid = 1'b1; r_in = pat(998);
      exp_v = sb_r.pop_front(); mcnt--;
      tick();
      ifr.out_ready = 1'b0; ifr.in_valid = 1'b0;
      vectors++; if (ifr.out_valid !== 1'b1 || r_out !== exp_v) begin miscompares++; $display("FAIL full_pop got %b/%h want 1/%h", ifr.out_valid, r_out, exp_v); end
      vectors++; if (r_count !== CW'(DP - 1) || ifr.in_ready !== 1'b1) begin miscompares++; $display("FAIL full_pop_cnt got %0d/%b want %0d/1", r_count, ifr.in_ready, DP - 1); end
      for (int c = 0; c < 100; c++) begin
         v  = WW'({$urandom(), $urandom(), $urandom()});
         wv = 1'($urandom_range(0, 1));
         rv = 1'($urandom_range(0, 1));
         rd_exp = rv && (mcnt > 0);
         wr_exp = wv && (mcnt < int'(DP));
         ifr.in_valid = wv; r_in = v; ifr.out_ready = rv;
         if (rd_exp) exp_v = sb_r.pop_front();
         if (wr_exp) sb_r.push_back(v);
         mcnt = mcnt + int'(wr_exp) - int'(rd_exp);
         tick();
         vectors++; if (ifr.out_valid !== rd_exp) begin miscompares++; $display("FAIL rnd_valid_%0d got %b want %b", c, ifr.out_valid, rd_exp); end
         if (rd_exp) begin
            vectors++; if (r_out !== exp_v) begin miscompares++; $display("FAIL rnd_data_%0d got %h want %h", c, r_out, exp_v); end
         end
         vectors++; if (r_count !== CW'(mcnt)) begin miscompares++; $display("FAIL rnd_count_%0d got %0d want %0d", c, r_count, mcnt); end
      end
      ifr.in_valid = 1'b0;
      while (mcnt > 0) begin
         ifr.out_ready = 1'b1;
         exp_v = sb_r.pop_front(); mcnt--;
         tick();
         vectors++; if (ifr.out_valid !== 1'b1 || r_out !== exp_v) begin miscompares++; $display("FAIL drain got %b/%h want 1/%h", ifr.out_valid, r_out, exp_v); end
      end
      ifr.out_ready = 1'b0;
      last_out = exp_v;
      clr_err = 1'b1; tick(); clr_err = 1'b0;
   endtask

   task automatic test_fwft();
      ifw.in_valid = 1'b1; w_in = pat(7); sb_w.push_back(pat(7));
      tick();
      ifw.in_valid = 1'b0;
      vectors++; if (w_count !== CW'(1) || w_empty !== 1'b0) begin miscompares++; $display("FAIL fw_cnt1 got %0d/%b want 1/0", w_count, w_empty); end
      tick();
      exp_v = sb_w.pop_front();
      vectors++; if (ifw.out_valid !== 1'b1 || w_out !== exp_v) begin miscompares++; $display("FAIL fw_first got %b/%h want 1/%h", ifw.out_valid, w_out, exp_v); end
      for (int j = 0; j < 5; j++) begin
         tick();
         vectors++; if (ifw.out_valid !== 1'b1 || w_out !== exp_v) begin miscompares++; $display("FAIL fw_stall_%0d got %b/%h want 1/%h", j, ifw.out_valid, w_out, exp_v); end
      end
      ifw.out_ready = 1'b1; tick(); ifw.out_ready = 1'b0;
      vectors++; if (ifw.out_valid !== 1'b0 || w_count !== CW'(0)) begin miscompares++; $display("FAIL fw_consume got %b/%0d want 0/0", ifw.out_valid, w_count); end
      ifw.out_ready = 1'b1; tick(); ifw.out_ready = 1'b0;
      vectors++; if (w_uf !== 1'b0 || ifw.out_valid !== 1'b0) begin miscompares++; $display("FAIL fw_no_uf got %b/%b want 0/0", w_uf, ifw.out_valid); end
      for (int k = 0; k < 4; k++) begin
         ifw.in_valid = 1'b1; w_in = pat(20 + k); sb_w.push_back(pat(20 + k));
         tick();
      end
      ifw.in_valid = 1'b0;
      exp_v = sb_w.pop_front();
      vectors++; if (w_count !== CW'(4) || ifw.out_valid !== 1'b1 || w_out !== exp_v) begin miscompares++; $display("FAIL fw_cnt4 got %0d/%b/%h want 4/1/%h", w_count, ifw.out_valid, w_out, exp_v); end
      vectors++; if (w_full !== 1'b0 || w_af !== 1'b0 || w_ae !== 1'b0 || ifw.in_ready !== 1'b1) begin miscompares++; $display("FAIL fw_flags4 got f=%b af=%b ae=%b rdy=%b", w_full, w_af, w_ae, ifw.in_ready); end
      ifw.in_valid = 1'b1; w_in = pat(24); sb_w.push_back(pat(24)); ifw.out_ready = 1'b1;
      tick();
      ifw.in_valid = 1'b0;
      exp_v = sb_w.pop_front();
      vectors++; if (w_count !== CW'(4)) begin miscompares++; $display("FAIL fw_simul_cnt got %0d want 4", w_count); end
      vectors++; if (ifw.out_valid !== 1'b1 || w_out !== exp_v) begin miscompares++; $display("FAIL fw_simul_head got %b/%h want 1/%h", ifw.out_valid, w_out, exp_v); end
      for (int j = 0; j < 3; j++) begin
         tick();
         exp_v = sb_w.pop_front();
         vectors++; if (ifw.out_valid !== 1'b1 || w_out !== exp_v || w_count !== CW'(3 - j)) begin miscompares++; $display("FAIL fw_stream_%0d got %b/%h/%0d want 1/%h/%0d", j, ifw.out_valid, w_out, w_count, exp_v, 3 - j); end
      end
      tick();
      ifw.out_ready = 1'b0;
      vectors++; if (ifw.out_valid !== 1'b0 || w_count !== CW'(0)) begin miscompares++; $display("FAIL fw_empty got %b/%0d want 0/0", ifw.out_valid, w_count); end
   endtask

   task automatic test_flush();
      for (int k = 0; k < 10; k++) req_push(pat(200 + k));
      vectors++; if (r_count !== CW'(10)) begin miscompares++; $display("FAIL fl_count10 got %0d want 10", r_count); end
      flush = 1'b1; ifr.in_valid = 1'b1; r_in = pat(250); ifr.out_ready = 1'b1;
      tick();
      flush = 1'b0; ifr.in_valid = 1'b0; ifr.out_ready = 1'b0;
      sb_r.delete(); mcnt = 0;
      vectors++; if (r_count !== CW'(0) || r_empty !== 1'b1) begin miscompares++; $display("FAIL fl_clear got %0d/%b want 0/1", r_count, r_empty); end
      vectors++; if (ifr.out_valid !== 1'b0 || r_uf !== 1'b0) begin miscompares++; $display("FAIL fl_valid_uf got %b/%b want 0/0", ifr.out_valid, r_uf); end
      vectors++; if (r_out !== last_out) begin miscompares++; $display("FAIL fl_hold got %h want %h", r_out, last_out); end
      req_push(pat(260));
      ifr.out_ready = 1'b1; exp_v = sb_r.pop_front(); mcnt--;
      tick();
      ifr.out_ready = 1'b0;
      vectors++; if (ifr.out_valid !== 1'b1 || r_out !== exp_v) begin miscompares++; $display("FAIL fl_after got %b/%h want 1/%h", ifr.out_valid, r_out, exp_v); end
      vectors++; if (r_count !== CW'(0)) begin miscompares++; $display("FAIL fl_after_cnt got %0d want 0", r_count); end
   endtask

   task automatic test_reset_mid();
      for (int k = 0; k < 7; k++) req_push(pat(300 + k));
      vectors++; if (r_count !== CW'(7)) begin miscompares++; $display("FAIL rm_count7 got %0d want 7", r_count); end
      rst = 1'b1;
      #1;
      vectors++; if (r_count !== CW'(0) || r_empty !== 1'b1 || r_full !== 1'b0) begin miscompares++; $display("FAIL rm_flags got %0d/%b/%b want 0/1/0", r_count, r_empty, r_full); end
      vectors++; if (ifr.in_ready !== 1'b1 || ifr.out_valid !== 1'b0 || r_uf !== 1'b0) begin miscompares++; $display("FAIL rm_hs got %b/%b/%b want 1/0/0", ifr.in_ready, ifr.out_valid, r_uf); end
      vectors++; if (r_out !== '0) begin miscompares++; $display("FAIL rm_out got %h want 0", r_out); end
      tick();
      rst = 1'b0;
      sb_r.delete(); mcnt = 0;
      req_push(pat(400));
      req_push(pat(401));
      ifr.out_ready = 1'b1; exp_v = sb_r.pop_front(); mcnt--;
      tick();
      ifr.out_ready = 1'b0;
      vectors++; if (ifr.out_valid !== 1'b1 || r_out !== exp_v) begin miscompares++; $display("FAIL rm_first got %b/%h want 1/%h", ifr.out_valid, r_out, exp_v); end
      vectors++; if (r_count !== CW'(1)) begin miscompares++; $display("FAIL rm_count got %0d want 1", r_count); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; flush = 1'b0; clr_err = 1'b0;
      ifr.in_valid = 1'b0; ifr.out_ready = 1'b0;
      ifw.in_valid = 1'b0; ifw.out_ready = 1'b0;
      r_in = '0; w_in = '0; mcnt = 0; last_out = '0; exp_v = '0;
      tick(); tick();
      test_reset();
      rst = 1'b0;
      tick();
      test_req_basic();
      test_underflow();
      test_full_wrap();
      test_fwft();
      test_flush();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/idx_vec_fifo.md
Name: idx_vec_fifo

Overview:
- Parametrised multi-lane index FIFO. Each entry is a vector of LANES indices, IDX_W bits each.
- Buffers index vectors between the index-generation stage and the FFT data-reorder/readout stage.
- Adds valid/ready handshakes, selectable first-word-fall-through (FWFT) or request-read mode, fill count, almost-full/almost-empty thresholds, synchronous flush and sticky underflow.

Parameters:
- IDX_W, 5, width of one index.
- LANES, 16, indices per entry.
- DEPTH, 32, entries; power of two, at least 2.
- AF_LEVEL, DEPTH-2, almost_full asserts when count >= AF_LEVEL.
- AE_LEVEL, 2, almost_empty asserts when count <= AE_LEVEL.
- FWFT, 0, 0 = request-read mode, 1 = first-word-fall-through.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- flush  in  1  synchronous clear of contents.
- in_valid  in  1  input vector valid.
- in_ready  out  1  FIFO can accept; equals !full.
- in_index  in  [IDX_W-1:0] x [0:LANES-1]  input index vector.
- out_ready  in  1  FWFT=1: consumer accepts head. FWFT=0: read request.
- out_valid  out  1  out_index holds valid data.
- out_index  out  [IDX_W-1:0] x [0:LANES-1]  registered output vector.
- count  out  $clog2(DEPTH+1)  words stored and not yet delivered.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  threshold flag.
- almost_empty  out  1  threshold flag.
- underflow  out  1  sticky error flag.
- clr_err  in  1  clears underflow.

Behaviour:
- Reset (rst high, asynchronous): pointers, count, out_valid and underflow = 0; out_index = 0; empty = 1; full = 0; in_ready = 1. Memory contents are not reset.
- Write: occurs on in_valid && in_ready. The vector is stored at wr_ptr and wr_ptr advances modulo DEPTH. in_valid while full is a legal stall: nothing is written and no flag is raised.
- in_ready, full, empty, almost_full and almost_empty are combinational from the registered count only, never from the same-cycle read. A pop at full therefore does not allow a write in that same cycle.
- FWFT=0 (request mode):
  - out_ready && !empty pops the entry at rd_ptr.
  - out_index is loaded at the next edge; out_valid pulses high for exactly one cycle. Latency is 1.
  - out_index holds its value when no read occurs.
  - out_ready while empty: no pop, out_valid = 0, underflow set.
- FWFT=1:
  - The output register acts as a one-entry head stage.
  - When the head is empty or being consumed (out_valid && out_ready) and storage is non-empty, the next entry loads the head at the next edge.
  - A write into a completely empty FIFO appears with out_valid = 1 one cycle later.
  - out_index and out_valid stay stable while out_valid && !out_ready.
  - underflow is never set in this mode.
- count semantics:
  - FWFT=1: count includes the word held in the head register; DEPTH counts total capacity including the head.
  - Simultaneous write and read/consume: count is unchanged, both pointers advance as applicable.
  - count never exceeds DEPTH and never goes below 0.
- Wrap-around: pointers are $clog2(DEPTH) bits and wrap naturally. full/empty derive from count, not from pointer compare.
- flush (synchronous):
  - Clears pointers, count and out_valid.
  - Overrides any same-cycle write or read; both are ignored and no underflow is raised.
  - out_index keeps its last value.
- underflow: cleared by clr_err. If clr_err and a new underflow event occur in the same cycle, set wins.
- rst asserted mid-transfer: immediate clear. The first accepted write after release is stored at entry 0.

Decomposition:
- Package idx_fifo_pkg holds:
  - idx_t: logic [IDX_W-1:0].
  - Default constants IDX_W_D = 5, LANES_D = 16, DEPTH_D = 32.
  - A ptr-width helper function.
- One sub-module, idx_vec_ram: a DEPTH x (LANES*IDX_W) simple dual-port RAM with registered read. The FIFO control packs and unpacks lane vectors to and from the flat RAM word.

Test Plan:
- FWFT=0, write 3 vectors, lane i = (k+i)%32 for k = 0,1,2; pulse out_ready 3 times -> out_valid one-cycle pulses one cycle after each request, vectors in order, count 3->0.
- FWFT=0, out_ready while empty -> out_valid stays 0, underflow = 1 and sticky; clr_err pulse -> underflow = 0.
- Fill 32 entries -> full = 1, in_ready = 0, almost_full from count 30. Write attempt at full is dropped. Pop one -> in_ready returns next cycle. Data intact across wrap for 100 random writes and reads.
- FWFT=1, single write into empty -> out_valid = 1 next cycle with that vector. Hold out_ready = 0 for 5 cycles -> out_index stable. Simultaneous write and consume with count = 4 -> count stays 4.
- flush asserted with count = 10, plus same-cycle in_valid and out_ready -> count = 0, empty = 1, out_valid = 0, no write stored, no underflow.
- Assert rst mid-stream with count = 7 -> all flags at reset values immediately; after release, the first written vector is the first read out.
